// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shift pattern in, pulse one capture cycle, shift response out, compare.
// Optional X-masking of the compare is enabled by defining SCAN_CTRL_XMASK_EN.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
`ifdef SCAN_CTRL_XMASK_EN
  input  logic [CHAIN_LEN-1:0] xmask_in,
`endif
  input  logic                 so,
  output logic                 tm,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_sh_q, resp_sh_d;
  logic [CHAIN_LEN-1:0] response_q, response_d;
  logic                 pass_q, pass_d;
  logic                 tm_q, tm_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] care;

`ifdef SCAN_CTRL_XMASK_EN
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  assign care = ~mask_q;
`else
  assign care = '1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    resp_sh_d  = resp_sh_q;
    response_d = response_q;
    pass_d     = pass_q;
`ifdef SCAN_CTRL_XMASK_EN
    mask_d     = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          pat_d   = pattern_in;
          exp_d   = expect_in;
`ifdef SCAN_CTRL_XMASK_EN
          mask_d  = xmask_in;
`endif
        end
      end
      ST_SHIFT: begin
        pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
        if (cnt_q == LAST_BIT) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_UNLOAD;
        cnt_d   = '0;
      end
      ST_UNLOAD: begin
        resp_sh_d = {resp_sh_q[CHAIN_LEN-2:0], so};
        // Result is published on the edge entering DONE so it is valid alongside done.
        if (cnt_q == LAST_BIT) begin
          state_d    = ST_DONE;
          cnt_d      = '0;
          response_d = resp_sh_d;
          pass_d     = ((resp_sh_d ^ exp_q) & care) == '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      response_d = response_q;
      pass_d     = pass_q;
    end

    tm_d   = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
    si_d   = (state_d == ST_SHIFT) && pat_d[CHAIN_LEN-1];
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_CAPTURE) || (state_d == ST_UNLOAD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
      resp_sh_q  <= '0;
      response_q <= '0;
      pass_q     <= 1'b0;
      tm_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SCAN_CTRL_XMASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      resp_sh_q  <= resp_sh_d;
      response_q <= response_d;
      pass_q     <= pass_d;
      tm_q       <= tm_d;
      si_q       <= si_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SCAN_CTRL_XMASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign tm       = tm_q;
  assign si       = si_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign response = response_q;

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer for a single scan chain built from basic mux-D scan cells. It owns the chain's test-mode (TM) and scan-in (SI) lines and observes scan-out (SO). On each request it shifts in one stimulus pattern, pulses a functional capture cycle, shifts the response out, and compares it against an expected vector. It sits between the test pattern source (bench or on-chip BIST sequencer) and the chain, replacing hand-driven TM/SI sequences.

## Interface
Parameters:
- CHAIN_LEN, 8, number of scan cells in the chain (≥2)
- CNT_W, $clog2(CHAIN_LEN+1), width of the internal bit counter

Ports:
- clk  in  1  rising-edge clock, shared with the scan cells
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request one test; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- pattern_in  in  CHAIN_LEN  stimulus; bit i loads cell i (cell 0 is nearest SI)
- expect_in  in  CHAIN_LEN  expected captured value; bit i is cell i
- so  in  1  chain scan-out, driven by cell CHAIN_LEN-1
- tm  out  1  test mode to all cells (1 = shift, 0 = functional capture)
- si  out  1  serial data into cell 0
- busy  out  1  high in SHIFT, CAPTURE, UNLOAD
- done  out  1  one-cycle pulse when a test completes
- pass  out  1  result of the last completed test; held until the next done
- response  out  CHAIN_LEN  captured chain contents, bit i = cell i; held

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: tm=0, si=0. start=1 at an edge latches pattern_in and expect_in, clears the counter, and moves to SHIFT.
- SHIFT: tm=1. si = latched pattern bit CHAIN_LEN-1-k on shift cycle k (k=0..CHAIN_LEN-1), so pattern bit CHAIN_LEN-1 goes in first. After CHAIN_LEN cycles, go to CAPTURE.
- CAPTURE: tm=0, si=0 for exactly one cycle; the cells load their functional D. Then go to UNLOAD.
- UNLOAD: tm=1, si=0. On each edge, so is sampled and shifted in: response <= {response[CHAIN_LEN-2:0], so}. After CHAIN_LEN samples, go to DONE.
- DONE: done=1 for one cycle. pass is registered as (response == expect), or as the masked compare under the macro. Then return to IDLE.
- start outside IDLE is ignored; there is no queueing.
- abort=1 at any edge forces IDLE: tm=0, si=0, no done, pass and response unchanged. abort has priority over start in the same cycle.
- tm, si, busy, done are decoded directly from flops (state register and pattern shift register). No combinational path from inputs to outputs.

## Timing
- Reset values: tm=0, si=0, busy=0, done=0, pass=0, response=0, state=IDLE.
- Reset asserted mid-test: immediate return to IDLE with all outputs at reset values. Chain contents are undefined afterwards.
- Latency: done is high in cycle 2·CHAIN_LEN+1 after the start-accept edge. The test occupies CHAIN_LEN SHIFT + 1 CAPTURE + CHAIN_LEN UNLOAD cycles.
- The first so sample is at the end of the first UNLOAD cycle and carries the captured value of cell CHAIN_LEN-1.
- Back-to-back tests: the earliest next start is accepted in the cycle after DONE. Throughput is one test per 2·CHAIN_LEN+3 cycles.
- pass and response update only in DONE.

## Configuration
- SCAN_CTRL_XMASK_EN defined: adds input xmask_in [CHAIN_LEN-1:0], latched with start. pass = ((response ^ expect) & ~xmask) == 0, so masked (X) cells are excluded from the compare.
- SCAN_CTRL_XMASK_EN undefined: no xmask_in port, and every bit is compared.

## Test plan
Bench model: a CHAIN_LEN=8 chain of scan cells whose functional D = ~Q (capture inverts).
- Reset: hold rst_n=0 → tm=0, si=0, busy=0, done=0, pass=0, response=0.
- Basic test: pattern_in=8'hA5, expect_in=8'h5A, start for one cycle → busy for 17 cycles; si sequence 1,0,1,0,0,1,0,1; tm low only in the capture cycle; done in cycle 17; response=8'h5A; pass=1.
- Mismatch: pattern_in=8'h0F, expect_in=8'hF1 → response=8'hF0, pass=0.
- Abort: assert abort in UNLOAD cycle 3 → tm=0 next cycle, no done; pass and response keep their previous values; a new start is accepted the following cycle.
- start while busy: pulse start in SHIFT with a different pattern → ignored; the original test completes with its latched values. Back-to-back: start in the cycle after DONE is accepted.
- Async reset mid-SHIFT: drop rst_n between edges → outputs go to reset values immediately. With SCAN_CTRL_XMASK_EN: pattern 8'h0F, expect 8'hF1, xmask 8'h01 → pass=1.
